data_mem_bus: RTL and testbench

- Downstream data-memory stage of the multi-cycle RV32I core; consumes the core's ramAddr/ramRStrb/memWData/memWMask and returns ramRData.
- Decodes each access to either an on-chip byte-maskable data RAM or a small IO window.
- The IO window holds an LED register and an 8N1 UART transmitter with a busy status flag.
- Sits between Processor and the FPGA pins; instruction ROM is not handled here.

---
 rtl/data_mem_bus_pkg.sv | 20 ++
 rtl/data_mem_bus_uart_tx.sv | 97 +++++++++
 rtl/data_mem_bus.sv | 101 ++++++++++
 tb/tb_data_mem_bus.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bus_pkg.sv
// Shared definitions for the data-memory bus: region select bit, IO register
// offsets and the UART transmitter state encoding.
package data_mem_bus_pkg;

    // ramAddr bit that separates the RAM (0) from the IO window (1)
    localparam int REGION_BIT = 22;

    // IO register offsets, taken from ramAddr[3:2]
    localparam logic [1:0] IO_LED       = 2'd0;
    localparam logic [1:0] IO_UART_DATA = 2'd1;
    localparam logic [1:0] IO_UART_STAT = 2'd2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/data_mem_bus_uart_tx.sv
// 8N1 serial transmitter (module uart_tx_8n1).
//
// state      | meaning
// -----------+------------------------------------------------
// UART_IDLE  | line high, not busy, waiting for start
// UART_START | start bit (line low) for one bit period
// UART_DATA  | 8 data bits LSB-first, one bit period each
// UART_STOP  | stop bit (line high) for one bit period
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   start  in   request to send data; honoured only in UART_IDLE
//   data   in   byte to send, latched when start is accepted
//   busy   out  high in every state except UART_IDLE
//   tx     out  serial line, idles high
module uart_tx_8n1
    import data_mem_bus_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    uart_state_t   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    tx_byte, tx_byte_d;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= UART_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            tx_byte <= tx_byte_d;
        end
    end

    // Outputs depend only on registered state, never on start/data.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        tx_byte_d = tx_byte;
        busy      = 1'b1;
        tx        = 1'b1;
        case (state)
            UART_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = UART_START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_byte_d = data;
                end
            end
            UART_START: begin
                tx    = 1'b0;
                cnt_d = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_d = UART_DATA;
            end
            UART_DATA: begin
                tx    = tx_byte[bit_idx];
                cnt_d = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_d = UART_STOP;
                    else bit_idx_d = bit_idx + 1'b1;
                end
            end
            UART_STOP: begin
                cnt_d = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_d = UART_IDLE;
            end
            default: state_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/data_mem_bus.sv
// Data-memory stage of the RV32I core: byte-maskable data RAM plus an IO
// window holding an LED register and an 8N1 UART transmitter.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   ramAddr   in   byte address from the core
//   ramRStrb  in   one-cycle read strobe
//   memWData  in   lane-replicated write data
//   memWMask  in   byte write enables (0000 = no write)
//   ramRData  out  registered read data, valid the cycle after the strobe
//   leds      out  LED register
//   uart_tx   out  serial line
module data_mem_bus
    import data_mem_bus_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int LED_W     = 5,
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ramAddr,
    input  logic             ramRStrb,
    input  logic [31:0]      memWData,
    input  logic [3:0]       memWMask,
    output logic [31:0]      ramRData,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    io_off;
    logic          ram_sel;
    logic          io_sel;
    logic          uart_start;
    logic          uart_busy;
    logic [31:0]   rd_word;
    logic          unused_addr;

    assign ram_sel  = ~ramAddr[REGION_BIT];
    assign io_sel   = ramAddr[REGION_BIT];
    assign word_idx = ramAddr[2 +: AW];
    assign io_off   = ramAddr[3:2];

    // Bits outside the decode are deliberately ignored (RAM index wraps).
    assign unused_addr = ^{ramAddr[31:23], ramAddr[21:0]};

    // RAM has no reset; lanes not enabled keep their contents.
    always_ff @(posedge clk) begin
        if (ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (memWMask[i]) mem[word_idx][8*i +: 8] <= memWData[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (ram_sel) begin
            rd_word = mem[word_idx];
        end else begin
            case (io_off)
                IO_LED:       rd_word[LED_W-1:0] = leds;
                IO_UART_STAT: rd_word[0] = uart_busy;
                default:      rd_word = '0;
            endcase
        end
    end

    // Nonblocking update gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ramRData <= '0;
            leds     <= '0;
        end else begin
            if (ramRStrb) ramRData <= rd_word;
            if (io_sel && (io_off == IO_LED) && memWMask[0]) leds <= memWData[LED_W-1:0];
        end
    end

    // A write while busy is dropped inside the transmitter.
    assign uart_start = io_sel && (io_off == IO_UART_DATA) && memWMask[0];

    uart_tx_8n1 #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (uart_start),
        .data  (memWData[7:0]),
        .busy  (uart_busy),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_data_mem_bus.sv
module tb_data_mem_bus;

    localparam int RAM_WORDS = 1024;
    localparam int LED_W     = 5;
    localparam int CLK_HZ    = 12000000;
    localparam int BAUD      = 3000000;
    localparam int DIV       = CLK_HZ / BAUD;

    localparam logic [31:0] A_LED  = 32'h0040_0000;
    localparam logic [31:0] A_UDAT = 32'h0040_0004;
    localparam logic [31:0] A_USTA = 32'h0040_0008;
    localparam logic [31:0] A_RSVD = 32'h0040_000C;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      ramAddr;
    logic             ramRStrb;
    logic [31:0]      memWData;
    logic [3:0]       memWMask;
    logic [31:0]      ramRData;
    logic [LED_W-1:0] leds;
    logic             uart_tx;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      wd;
        logic [3:0]       m;
        logic             s;
        logic [31:0]      e;
        logic             lc;
        logic [LED_W-1:0] le;
    } step_t;

    data_mem_bus #(
        .RAM_WORDS (RAM_WORDS),
        .LED_W     (LED_W),
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ramAddr  (ramAddr),
        .ramRStrb (ramRStrb),
        .memWData (memWData),
        .memWMask (memWMask),
        .ramRData (ramRData),
        .leds     (leds),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    // One bus cycle; a strobe pushes its expected read data to the scoreboard.
    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                       input logic s, input logic [31:0] e);
        ramAddr  = a;
        memWData = wd;
        memWMask = m;
        ramRStrb = s;
        if (s) exp_q.push_back(e);
        @(posedge clk);
        #1;
        memWMask = 4'h0;
        ramRStrb = 1'b0;
    endtask

    function automatic step_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                                 input logic s, input logic [31:0] e, input logic lc,
                                 input logic [LED_W-1:0] le);
        step_t st;
        st.a = a; st.wd = wd; st.m = m; st.s = s; st.e = e; st.lc = lc; st.le = le;
        return st;
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        ramAddr  = '0;
        memWData = '0;
        memWMask = '0;
        ramRStrb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ramRData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", ramRData, 32'h0); end
        total++;
        if (leds !== '0) begin bad++; $display("FAIL reset_leds got=%h exp=0", leds); end
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        reset = 1'b1;
    endtask

    task automatic test_ram();
        step_t st[$];
        logic [31:0] e;
        st.push_back(mk(32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 0, 0));
        st.push_back(mk(32'h10,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 0));
        st.push_back(mk(32'h10,   32'h00AA0000, 4'h4, 0, 0, 0, 0));
        st.push_back(mk(32'h10,   32'h0,        4'h0, 1, 32'hDEAABEEF, 0, 0));
        st.push_back(mk(32'h10 + 4*RAM_WORDS, 32'h0, 4'h0, 1, 32'hDEAABEEF, 0, 0));
        st.push_back(mk(32'h20,   32'h12345678, 4'hF, 0, 0, 0, 0));
        st.push_back(mk(32'h20,   32'hCAFEF00D, 4'hF, 1, 32'h12345678, 0, 0));
        st.push_back(mk(32'h23,   32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 0));
        st.push_back(mk(32'h24,   32'h0,        4'hF, 0, 0, 0, 0));
        st.push_back(mk(32'h24,   32'hFFFFFFFF, 4'h9, 0, 0, 0, 0));
        st.push_back(mk(32'h24,   32'h0,        4'h0, 1, 32'hFF0000FF, 0, 0));
        foreach (st[i]) begin
            bus(st[i].a, st[i].wd, st[i].m, st[i].s, st[i].e);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (ramRData !== e) begin bad++; $display("FAIL ram_step%0d got=%h exp=%h", i, ramRData, e); end
            end
        end
    endtask

    task automatic test_read_hold();
        logic [31:0] e;
        logic [31:0] held;
        bus(32'h20, 32'h0, 4'h0, 1, 32'hCAFEF00D);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL hold_load got=%h exp=%h", ramRData, e); end
        held = e;
        bus(32'h20, 32'h0BADF00D, 4'hF, 0, 0);
        bus(32'h24, 32'h0, 4'h0, 0, 0);
        bus(A_USTA, 32'h0, 4'h0, 0, 0);
        total++;
        if (ramRData !== held) begin bad++; $display("FAIL hold_keep got=%h exp=%h", ramRData, held); end
        bus(32'h20, 32'h0, 4'h0, 1, 32'h0BADF00D);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL hold_next got=%h exp=%h", ramRData, e); end
    endtask

    task automatic test_io();
        step_t st[$];
        logic [31:0] e;
        st.push_back(mk(32'h0,  32'h11223344, 4'hF, 0, 0, 0, 0));
        st.push_back(mk(A_LED,  32'h00000015, 4'h1, 0, 0, 1, 5'h15));
        st.push_back(mk(A_LED,  32'h0,        4'h0, 1, 32'h15, 1, 5'h15));
        st.push_back(mk(A_RSVD, 32'h0,        4'h0, 1, 32'h0, 0, 0));
        st.push_back(mk(A_UDAT, 32'h0,        4'h0, 1, 32'h0, 0, 0));
        st.push_back(mk(A_USTA, 32'h0,        4'h0, 1, 32'h0, 0, 0));
        st.push_back(mk(32'h0,  32'h0,        4'h0, 1, 32'h11223344, 0, 0));
        st.push_back(mk(A_LED,  32'h0000000A, 4'h2, 0, 0, 1, 5'h15));
        st.push_back(mk(A_RSVD, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 1, 5'h15));
        st.push_back(mk(32'h8040_0000, 32'h0000000A, 4'h1, 0, 0, 1, 5'h0A));
        st.push_back(mk(32'h0,  32'h0,        4'h0, 1, 32'h11223344, 0, 0));
        foreach (st[i]) begin
            bus(st[i].a, st[i].wd, st[i].m, st[i].s, st[i].e);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (ramRData !== e) begin bad++; $display("FAIL io_step%0d got=%h exp=%h", i, ramRData, e); end
            end
            if (st[i].lc) begin
                total++;
                if (leds !== st[i].le) begin bad++; $display("FAIL io_leds%0d got=%h exp=%h", i, leds, st[i].le); end
            end
        end
    endtask

    task automatic test_uart_frame();
        logic [7:0]  byte_v;
        logic [9:0]  frame;
        logic [31:0] e;
        int          lows;
        byte_v = 8'h41;
        frame  = {1'b1, byte_v, 1'b0};
        bus(A_UDAT, {24'h0, byte_v}, 4'h1, 0, 0);
        for (int k = 0; k < 10*DIV; k++) begin
            total++;
            if (uart_tx !== frame[k/DIV]) begin
                bad++; $display("FAIL uart_bit k=%0d got=%b exp=%b", k, uart_tx, frame[k/DIV]);
            end
            if (k == 10) bus(A_UDAT, 32'h42, 4'h1, 0, 0);
            else if (k == 10*DIV - 1) bus(A_UDAT, 32'h55, 4'h1, 1, 32'h0);
            else bus(A_USTA, 32'h0, 4'h0, 1, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (ramRData !== e) begin bad++; $display("FAIL uart_stat k=%0d got=%h exp=%h", k, ramRData, e); end
            end
        end
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL uart_idle_tx got=%b exp=1", uart_tx); end
        bus(A_USTA, 32'h0, 4'h0, 1, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL uart_stat_done got=%h exp=%h", ramRData, e); end
        lows = 0;
        for (int k = 0; k < 12*DIV; k++) begin
            if (uart_tx !== 1'b1) lows++;
            bus(32'h0, 32'h0, 4'h0, 0, 0);
        end
        total++;
        if (lows != 0) begin bad++; $display("FAIL uart_no_second_frame got=%0d exp=0", lows); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] e;
        int          lows;
        bus(A_LED, 32'h1F, 4'h1, 0, 0);
        bus(32'h10, 32'h0, 4'h0, 1, 32'hDEAABEEF);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL rst_pre_rd got=%h exp=%h", ramRData, e); end
        bus(A_UDAT, 32'h00, 4'h1, 0, 0);
        lows = 0;
        for (int k = 0; k < 3*DIV + 2; k++) begin
            if (uart_tx === 1'b0) lows++;
            bus(32'h0, 32'h0, 4'h0, 0, 0);
        end
        total++;
        if (lows == 0) begin bad++; $display("FAIL rst_frame_active got=%0d lows exp>0", lows); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_mid_tx got=%b exp=1", uart_tx); end
        total++;
        if (leds !== '0) begin bad++; $display("FAIL rst_mid_leds got=%h exp=0", leds); end
        total++;
        if (ramRData !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=0", ramRData); end
        reset = 1'b1;
        bus(A_USTA, 32'h0, 4'h0, 1, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL rst_mid_stat got=%h exp=%h", ramRData, e); end
        bus(32'h10, 32'h0, 4'h0, 1, 32'hDEAABEEF);
        e = exp_q.pop_front();
        total++;
        if (ramRData !== e) begin bad++; $display("FAIL rst_ram_kept got=%h exp=%h", ramRData, e); end
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx_stays got=%b exp=1", uart_tx); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_read_hold();
        test_io();
        test_uart_frame();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
